// File: rtl/gambit_brupd_pkg.sv
// Shared types and helpers for the branch-commit to predictor-update path.
package gambit_brupd_pkg;

    localparam int BRUPD_AMSB       = 51;
    localparam int BRUPD_NSLOTS     = 4;
    localparam int BRUPD_FIFO_DEPTH = 32;
    localparam int BRUPD_DROPW      = 16;

    typedef struct packed {
        logic                  taken;
        logic [BRUPD_AMSB:0]   ip;
    } brupd_entry_t;

    // A slot survives if it is a branch and no lower slot was a taken branch.
    function automatic logic [BRUPD_NSLOTS-1:0] first_taken_mask(
        input logic [BRUPD_NSLOTS-1:0] is_br,
        input logic [BRUPD_NSLOTS-1:0] takb
    );
        logic [BRUPD_NSLOTS-1:0] mask;
        logic                    seen;
        mask = '0;
        seen = 1'b0;
        for (int i = 0; i < BRUPD_NSLOTS; i++) begin
            mask[i] = is_br[i] & ~seen;
            seen    = seen | (is_br[i] & takb[i]);
        end
        return mask;
    endfunction

endpackage

// File: rtl/brupd_fifo.sv
// Single-clock FIFO of update records; head is read combinationally, push accepted after 1 edge.
// When full, a push is only accepted if a pop happens in the same cycle; otherwise push_drop pulses.
module brupd_fifo
    import gambit_brupd_pkg::*;
#(
    parameter int DEPTH = BRUPD_FIFO_DEPTH
) (
    input  logic                     clk4x,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_vld,
    input  brupd_entry_t             push_dat,
    input  logic                     pop,
    output brupd_entry_t             head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     push_drop
);

    localparam int AW = $clog2(DEPTH);

    brupd_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          pop_en;
    logic          push_en;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign pop_en    = pop & ~empty;
    // Full is judged before the pop, so a simultaneous pop frees the slot.
    assign push_en   = push_vld & (~full | pop_en) & ~flush;
    assign push_drop = push_vld & ~(~full | pop_en) & ~flush;
    assign head_dat  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop_en};
        count_d  = count_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk4x) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk4x) begin
        if (!rst && push_en) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/branch_commit_serializer.sv
// Captures a commit group on cmt_stb, drains surviving branches one per cycle into the update FIFO.
// First record visible one edge after capture; upd_valid holds until upd_ready, full FIFO drops records.
module branch_commit_serializer
    import gambit_brupd_pkg::*;
#(
    parameter int AMSB               = BRUPD_AMSB,
    parameter int NSLOTS             = BRUPD_NSLOTS,
    parameter int FIFO_DEPTH         = BRUPD_FIFO_DEPTH,
    parameter int SQUASH_AFTER_TAKEN = 1
) (
    input  logic                           clk4x,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           flush,
    input  logic                           cmt_stb,
    input  logic [NSLOTS-1:0]              xisBranch,
    input  logic [NSLOTS-1:0]              takb,
    input  logic [NSLOTS-1:0][AMSB:0]      xip,
    output logic                           upd_valid,
    input  logic                           upd_ready,
    output logic                           upd_taken,
    output logic [AMSB:0]                  upd_ip,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic [BRUPD_DROPW-1:0]         drop_cnt,
    output logic                           overrun
);

    localparam int SLW = $clog2(NSLOTS);

    logic [NSLOTS-1:0]          pend_q, pend_d;
    logic [NSLOTS-1:0]          stg_taken_q, stg_taken_d;
    logic [NSLOTS-1:0][AMSB:0]  stg_ip_q, stg_ip_d;
    logic [BRUPD_DROPW-1:0]     drop_cnt_q, drop_cnt_d;
    logic                       overrun_q, overrun_d;

    logic [NSLOTS-1:0]          cap_mask;
    logic [SLW-1:0]             sel;
    logic                       cap;
    logic                       push_vld;
    brupd_entry_t               push_dat;
    brupd_entry_t               head_dat;
    logic                       fifo_empty;
    logic                       push_drop;
    logic                       pop;

    assign cap      = cmt_stb & en;
    assign cap_mask = (SQUASH_AFTER_TAKEN != 0) ? first_taken_mask(xisBranch, takb) : xisBranch;
    assign push_vld = |pend_q;
    assign pop      = upd_valid & upd_ready;

    always_comb begin
        sel = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel = i[SLW-1:0];
            end
        end
    end

    always_comb begin
        push_dat.taken = stg_taken_q[sel];
        push_dat.ip    = stg_ip_q[sel];
    end

    always_comb begin
        pend_d      = pend_q;
        stg_taken_d = stg_taken_q;
        stg_ip_d    = stg_ip_q;
        overrun_d   = overrun_q;
        drop_cnt_d  = drop_cnt_q;

        if (push_vld) begin
            pend_d[sel] = 1'b0;
        end

        // flush wins over a same-cycle strobe; an overlapping strobe discards the old leftovers.
        if (flush) begin
            pend_d = '0;
        end else if (cap) begin
            pend_d      = cap_mask;
            stg_taken_d = takb;
            stg_ip_d    = xip;
            if (push_vld) begin
                overrun_d = 1'b1;
            end
        end

        if (push_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk4x) begin
        if (rst) begin
            pend_q      <= '0;
            stg_taken_q <= '0;
            stg_ip_q    <= '0;
            overrun_q   <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            stg_taken_q <= stg_taken_d;
            stg_ip_q    <= stg_ip_d;
            overrun_q   <= overrun_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    brupd_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk4x     (clk4x),
        .rst       (rst),
        .flush     (flush),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .pop       (pop),
        .head_dat  (head_dat),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .push_drop (push_drop)
    );

    assign upd_valid = ~fifo_empty;
    assign upd_taken = head_dat.taken;
    assign upd_ip    = head_dat.ip;
    assign drop_cnt  = drop_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_branch_commit_serializer.sv
// Directed bench: table of commit groups plus hand-built fill, overrun, flush and reset sequences.
module tb_branch_commit_serializer;

    logic              clk4x = 1'b0;
    logic              rst, en, flush, cmt_stb, upd_ready;
    logic [3:0]        xisBranch, takb;
    logic [3:0][51:0]  xip;

    logic              u1_valid, u1_taken, u1_overrun;
    logic [51:0]       u1_ip;
    logic [5:0]        u1_count;
    logic [15:0]       u1_drop;
    logic              u0_valid, u0_taken, u0_overrun;
    logic [51:0]       u0_ip;
    logic [5:0]        u0_count;
    logic [15:0]       u0_drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk4x = ~clk4x;

    branch_commit_serializer #(.SQUASH_AFTER_TAKEN(1)) dut (
        .clk4x(clk4x), .rst(rst), .en(en), .flush(flush), .cmt_stb(cmt_stb),
        .xisBranch(xisBranch), .takb(takb), .xip(xip),
        .upd_valid(u1_valid), .upd_ready(upd_ready), .upd_taken(u1_taken), .upd_ip(u1_ip),
        .fifo_count(u1_count), .drop_cnt(u1_drop), .overrun(u1_overrun)
    );

    branch_commit_serializer #(.SQUASH_AFTER_TAKEN(0)) dut_nosq (
        .clk4x(clk4x), .rst(rst), .en(en), .flush(flush), .cmt_stb(cmt_stb),
        .xisBranch(xisBranch), .takb(takb), .xip(xip),
        .upd_valid(u0_valid), .upd_ready(upd_ready), .upd_taken(u0_taken), .upd_ip(u0_ip),
        .fifo_count(u0_count), .drop_cnt(u0_drop), .overrun(u0_overrun)
    );

    typedef struct {
        logic [3:0]  br;
        logic [3:0]  tk;
        logic        en;
        logic [51:0] base;
        logic [3:0]  exp1;   // slots emitted with squash enabled
        logic [3:0]  exp0;   // slots emitted with squash disabled
    } vec_t;

    vec_t        vecs [7];
    logic [51:0] q [$];
    logic [51:0] seq [5];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk4x);
        #1;
    endtask

    task automatic send_group(input logic [3:0] br, input logic [3:0] tk,
                              input logic [51:0] base, input logic e);
        xisBranch = br;
        takb      = tk;
        en        = e;
        for (int i = 0; i < 4; i++) xip[i] = base + 52'(i * 4);
        cmt_stb = 1'b1;
        tick();
        cmt_stb = 1'b0;
    endtask

    function automatic int nth_slot(input logic [3:0] m, input int k);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (n == k) return i;
                n++;
            end
        end
        return 0;
    endfunction

    initial begin
        vecs[0] = '{4'b1011, 4'b0000, 1'b1, 52'h100, 4'b1011, 4'b1011};
        vecs[1] = '{4'b1111, 4'b0010, 1'b1, 52'h200, 4'b0011, 4'b1111};
        vecs[2] = '{4'b0000, 4'b1111, 1'b1, 52'h300, 4'b0000, 4'b0000};
        vecs[3] = '{4'b1010, 4'b1010, 1'b1, 52'h400, 4'b0010, 4'b1010};
        vecs[4] = '{4'b0110, 4'b0100, 1'b1, 52'h500, 4'b0110, 4'b0110};
        vecs[5] = '{4'b1101, 4'b0001, 1'b1, 52'h600, 4'b0001, 4'b1101};
        vecs[6] = '{4'b1111, 4'b0000, 1'b0, 52'h700, 4'b0000, 4'b0000};

        rst = 1'b1; en = 1'b0; flush = 1'b0; cmt_stb = 1'b0; upd_ready = 1'b0;
        xisBranch = '0; takb = '0;
        for (int i = 0; i < 4; i++) xip[i] = '0;
        repeat (3) tick();
        chk("rst_valid",   u1_valid,   0);
        chk("rst_count",   u1_count,   0);
        chk("rst_drop",    u1_drop,    0);
        chk("rst_overrun", u1_overrun, 0);
        rst = 1'b0;
        tick();

        // Table of single groups, consumer always ready.
        upd_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            send_group(vecs[v].br, vecs[v].tk, vecs[v].base, vecs[v].en);
            chk($sformatf("v%0d_cap_idle", v), u1_valid, 0);
            for (int k = 1; k <= 5; k++) begin
                tick();
                if (k <= $countones(vecs[v].exp1)) begin
                    int s;
                    s = nth_slot(vecs[v].exp1, k - 1);
                    chk($sformatf("v%0d_k%0d_sq_valid", v, k), u1_valid, 1);
                    chk($sformatf("v%0d_k%0d_sq_ip", v, k), u1_ip, vecs[v].base + 52'(4 * s));
                    chk($sformatf("v%0d_k%0d_sq_taken", v, k), u1_taken, vecs[v].tk[s]);
                end else begin
                    chk($sformatf("v%0d_k%0d_sq_idle", v, k), u1_valid, 0);
                end
                if (k <= $countones(vecs[v].exp0)) begin
                    int s;
                    s = nth_slot(vecs[v].exp0, k - 1);
                    chk($sformatf("v%0d_k%0d_nosq_valid", v, k), u0_valid, 1);
                    chk($sformatf("v%0d_k%0d_nosq_ip", v, k), u0_ip, vecs[v].base + 52'(4 * s));
                    chk($sformatf("v%0d_k%0d_nosq_taken", v, k), u0_taken, vecs[v].tk[s]);
                end else begin
                    chk($sformatf("v%0d_k%0d_nosq_idle", v, k), u0_valid, 0);
                end
            end
        end

        // Fill with consumer stalled: 36 records into 32 entries.
        upd_ready = 1'b0;
        for (int g = 0; g < 9; g++) begin
            send_group(4'b1111, 4'b0000, 52'h1000 + 52'(g * 64), 1'b1);
            if (g < 8) begin
                for (int s = 0; s < 4; s++) q.push_back(52'h1000 + 52'(g * 64 + s * 4));
            end
            repeat (4) tick();
        end
        chk("fill_count",   u1_count,   32);
        chk("fill_drop",    u1_drop,    4);
        chk("fill_overrun", u1_overrun, 0);
        chk("fill_head",    u1_ip,      52'h1000);

        // Push into a full FIFO in the same cycle as a pop.
        send_group(4'b1111, 4'b0000, 52'h1800, 1'b1);
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        chk("fullpop_count", u1_count, 32);
        chk("fullpop_drop",  u1_drop,  4);
        chk("fullpop_head",  u1_ip,    52'h1004);
        void'(q.pop_front());
        q.push_back(52'h1800);
        repeat (3) tick();
        chk("full_drop_after", u1_drop,  7);
        chk("full_count_after", u1_count, 32);

        upd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("drain%0d_valid", i), u1_valid, 1);
            chk($sformatf("drain%0d_ip", i),    u1_ip,    q[i]);
            tick();
        end
        chk("drain_end_valid", u1_valid, 0);
        chk("drain_end_count", u1_count, 0);

        // Back-to-back strobes: one record of the first group survives.
        send_group(4'b1111, 4'b0000, 52'h2000, 1'b1);
        send_group(4'b1111, 4'b0000, 52'h3000, 1'b1);
        seq[0] = 52'h2000; seq[1] = 52'h3000; seq[2] = 52'h3004;
        seq[3] = 52'h3008; seq[4] = 52'h300C;
        chk("ovr_flag", u1_overrun, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ovr%0d_valid", i), u1_valid, 1);
            chk($sformatf("ovr%0d_ip", i),    u1_ip,    seq[i]);
            tick();
        end
        chk("ovr_end_valid", u1_valid, 0);
        chk("ovr_drop",      u1_drop,  7);

        // Flush with count=5 and staging still pending.
        upd_ready = 1'b0;
        send_group(4'b1111, 4'b0000, 52'h4000, 1'b1);
        repeat (4) tick();
        send_group(4'b1111, 4'b0000, 52'h5000, 1'b1);
        tick();
        chk("preflush_count", u1_count, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid",   u1_valid,   0);
        chk("flush_count",   u1_count,   0);
        chk("flush_overrun", u1_overrun, 1);
        chk("flush_drop",    u1_drop,    7);
        repeat (4) tick();
        chk("postflush_valid", u1_valid, 0);
        chk("postflush_count", u1_count, 0);

        // Reset mid-drain.
        send_group(4'b1111, 4'b0000, 52'h6000, 1'b1);
        repeat (2) tick();
        chk("prerst_count", u1_count, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid",   u1_valid,   0);
        chk("midrst_count",   u1_count,   0);
        chk("midrst_drop",    u1_drop,    0);
        chk("midrst_overrun", u1_overrun, 0);
        repeat (4) tick();
        chk("postrst_valid", u1_valid, 0);
        chk("postrst_count", u1_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_commit_serializer.md
Name: branch_commit_serializer

Overview:
- Sits directly upstream of the gshare predictor's history-update path.
- Captures the up-to-4-slot commit group of branch outcomes each commit cycle and masks slots that follow a taken branch.
- Serialises surviving branches into a FIFO in the clk4x domain and presents them one per cycle, with valid/ready, as predictor update records {taken, ip}.
- Replaces ad-hoc clk/clk2x phase muxing with an explicit commit strobe.

Parameters:
- AMSB, 51, MSB of instruction address.
- NSLOTS, 4, commit slots per group.
- FIFO_DEPTH, 32, update FIFO entries (power of 2).
- SQUASH_AFTER_TAKEN, 1, when 1, slots after the first taken branch in a group are discarded.

Ports:
- clk4x  input  1  clock (4x commit clock).
- rst  input  1  reset.
- en  input  1  capture enable; groups strobed while en=0 are ignored.
- flush  input  1  clear staging and FIFO.
- cmt_stb  input  1  one-cycle strobe: commit group valid this cycle.
- xisBranch  input  NSLOTS  per-slot "is branch".
- takb  input  NSLOTS  per-slot taken outcome.
- xip  input  [AMSB:0] x NSLOTS  per-slot branch address.
- upd_valid  output  1  head update record valid.
- upd_ready  input  1  consumer accepts head.
- upd_taken  output  1  head taken bit.
- upd_ip  output  AMSB+1  head address.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy.
- drop_cnt  output  16  saturating count of records lost to FIFO full.
- overrun  output  1  sticky: strobe arrived while staging non-empty.

Behaviour:
- Reset is synchronous, active-high, on clk4x. Reset values: upd_valid=0, fifo_count=0, drop_cnt=0, overrun=0, staging mask=0, pointers=0. upd_ip/upd_taken are don't-care while upd_valid=0.
- Capture (edge where cmt_stb&en):
  - pend[i] = xisBranch[i], ANDed (if SQUASH_AFTER_TAKEN) with no lower slot j<i having xisBranch[j]&takb[j].
  - Load {takb, xip} for all slots into the staging registers.
- Drain: each cycle pend!=0, push the lowest set slot into the FIFO and clear its pend bit. Exactly one push per cycle, so at most NSLOTS cycles per group.
- Latency: strobe sampled at edge E0; first push at E1; upd_valid=1 after E1 (FIFO head read is combinational from distributed RAM).
- Overrun: cmt_stb&en while pend!=0 sets overrun (sticky until rst). The new group replaces the staging contents; remaining old records are lost and not counted in drop_cnt.
- FIFO:
  - Pop when upd_valid&upd_ready.
  - Full = count==FIFO_DEPTH, evaluated before the pop. A push in the same cycle as a pop while full is accepted; count is unchanged.
  - Push while full without a pop drops the record: drop_cnt+1, saturating at 16'hFFFF; staging still advances.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Simultaneous push and pop: count unchanged.
- flush: same cycle effect as reset for pend, pointers and count (upd_valid=0 next cycle). drop_cnt and overrun are retained. flush has priority over cmt_stb in the same cycle.
- upd_valid stays asserted, with upd_ip/upd_taken stable, until accepted. No combinational path from upd_ready to upd_valid.
- A group with no branches, or with en=0, produces nothing.

Decomposition:
- Package gambit_brupd_pkg:
  - typedef brupd_entry_t {logic taken; logic [AMSB:0] ip;}
  - localparams BRUPD_FIFO_DEPTH=32 and BRUPD_DROPW=16.
  - function first_taken_mask(isBr, takb) returning the slot-valid mask.
- Sub-module brupd_fifo: synchronous single-clock FIFO of brupd_entry_t with count/full/empty and the full-with-pop push rule.
- Staging, priority encoder, counters and flags stay in the top.

Test Plan:
- Group isBr=4'b1011, takb=4'b0000, ip={0x100,0x104,0x108,0x10C}, upd_ready=1 -> records (0,0x100),(0,0x104),(0,0x10C) on consecutive cycles starting 1 cycle after capture.
- Group isBr=4'b1111, takb=4'b0010 -> only (0,slot0),(1,slot1) emitted; with SQUASH_AFTER_TAKEN=0 all four emitted.
- upd_ready=0, 9 groups of 4 branches -> fifo_count=32, drop_cnt=4. Then ready=1 -> 32 records pop in order, fifo_count=0.
- Full FIFO with upd_ready=1 and a push in the same cycle -> push accepted, count stays 32, drop_cnt unchanged.
- cmt_stb on consecutive cycles, each group with isBr=4'b1111 -> overrun=1; the second group's 4 records are emitted, and only 1 record from the first group precedes them.
- flush while count=5 and pend!=0 -> next cycle upd_valid=0, fifo_count=0, no stale records later. rst mid-drain -> all outputs at reset values next cycle.
